// File: rtl/brcmp_pkg.sv
// Shared definitions for the iterative branch comparator: funct3 encodings,
// FSM states, and the funct3-to-branch-decision mapping.
package brcmp_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic taken;
        logic err;
    } decision_t;

    // funct3 010/011 are not branches: never taken, flagged as an error.
    function automatic decision_t branch_decide(
        input logic [2:0] mode,
        input logic       eq,
        input logic       lt,
        input logic       ltu
    );
        decision_t d;
        d.taken = 1'b0;
        d.err   = 1'b0;
        case (mode)
            F3_BEQ:  d.taken = eq;
            F3_BNE:  d.taken = ~eq;
            F3_BLT:  d.taken = lt;
            F3_BGE:  d.taken = ~lt;
            F3_BLTU: d.taken = ltu;
            F3_BGEU: d.taken = ~ltu;
            default: d.err   = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/chunk_subtractor.sv
// One slice of A - B computed as A + ~B + CIN; ZERO flags an all-zero slice difference.
module chunk_subtractor #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] A_k,
    input  logic [CHUNK-1:0] B_k,
    input  logic             CIN,
    output logic [CHUNK-1:0] S,
    output logic             COUT,
    output logic             ZERO
);

    logic [CHUNK:0] sum;

    assign sum  = {1'b0, A_k} + {1'b0, ~B_k} + {{CHUNK{1'b0}}, CIN};
    assign S    = sum[CHUNK-1:0];
    assign COUT = sum[CHUNK];
    assign ZERO = (sum[CHUNK-1:0] == '0);

endmodule

// File: rtl/branch_comparator_iter.sv
// Multi-cycle RV32I branch comparator: subtracts one slice per cycle, LSB first.
// Define BRCMP_SINGLE_CYCLE_EN to process the whole operand in a single RUN cycle.
module branch_comparator_iter
    import brcmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic             EQ,
    output logic             LT,
    output logic             LTU,
    output logic             TAKEN,
    output logic             ERR
);

`ifdef BRCMP_SINGLE_CYCLE_EN
    localparam int CH = WIDTH;
`else
    localparam int CH = CHUNK;
`endif
    localparam int NCH = WIDTH / CH;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             eqacc_q, eqacc_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             ltu_q, ltu_d;
    logic             taken_q, taken_d;
    logic             err_q, err_d;

    logic             accept;
    logic             last_slice;
    logic [CH-1:0]    a_k, b_k;
    logic [CH-1:0]    s_k;
    logic             cout_k;
    logic             zero_k;
    logic             eq_fin, ltu_fin, lt_fin;
    decision_t        dec;

    // Slice views of the latched operands; the counter picks one per cycle.
    logic [CH-1:0] a_sl [NCH];
    logic [CH-1:0] b_sl [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
            assign a_sl[gi] = a_q[gi*CH +: CH];
            assign b_sl[gi] = b_q[gi*CH +: CH];
        end
    endgenerate

    always_comb begin
        a_k = '0;
        b_k = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cnt_q == CW'(k)) begin
                a_k = a_sl[k];
                b_k = b_sl[k];
            end
        end
    end

    chunk_subtractor #(
        .CHUNK (CH)
    ) u_sub (
        .A_k  (a_k),
        .B_k  (b_k),
        .CIN  (carry_q),
        .S    (s_k),
        .COUT (cout_k),
        .ZERO (zero_k)
    );

    assign accept     = START && (state_q != S_RUN);
    assign last_slice = (cnt_q == CW'(NCH - 1));

    // Final-slice results; the signed compare only differs when the signs disagree.
    assign ltu_fin = ~cout_k;
    assign eq_fin  = eqacc_q & zero_k;
    assign lt_fin  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? a_q[WIDTH-1] : ltu_fin;
    assign dec     = branch_decide(mode_q, eq_fin, lt_fin, ltu_fin);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_RUN;
            S_RUN:   if (last_slice) state_d = S_DONE;
            S_DONE:  state_d = START ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        eqacc_d = eqacc_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        ltu_d   = ltu_q;
        taken_d = taken_q;
        err_d   = err_q;
        if (accept) begin
            a_d     = A;
            b_d     = B;
            mode_d  = MODE;
            cnt_d   = '0;
            carry_d = 1'b1;
            eqacc_d = 1'b1;
            eq_d    = 1'b0;
            lt_d    = 1'b0;
            ltu_d   = 1'b0;
            taken_d = 1'b0;
            err_d   = 1'b0;
        end else if (state_q == S_RUN) begin
            carry_d = cout_k;
            eqacc_d = eqacc_q & zero_k;
            if (last_slice) begin
                cnt_d   = '0;
                eq_d    = eq_fin;
                lt_d    = lt_fin;
                ltu_d   = ltu_fin;
                taken_d = dec.taken;
                err_d   = dec.err;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b1;
            eqacc_q <= 1'b1;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            ltu_q   <= 1'b0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            eqacc_q <= eqacc_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            ltu_q   <= ltu_d;
            taken_q <= taken_d;
            err_q   <= err_d;
        end
    end

    assign BUSY  = (state_q == S_RUN);
    assign DONE  = (state_q == S_DONE);
    assign EQ    = eq_q;
    assign LT    = lt_q;
    assign LTU   = ltu_q;
    assign TAKEN = taken_q;
    assign ERR   = err_q;

endmodule

// File: doc/branch_comparator_iter.md
Name: branch_comparator_iter

Overview:
- Multi-cycle, parametrised comparator for the RV32I branch unit. Evaluates A-B one CHUNK-bit slice per cycle, LSB first, with a registered carry and zero accumulator.
- Produces EQ, signed LT and unsigned LTU, plus a branch-taken decision selected by funct3.
- Sits between register-file read and PC-select. Trades latency for a short carry chain so it can replace the single-cycle ALU comparators on timing-critical builds.

Parameters:
- WIDTH, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle. NCH = WIDTH/CHUNK (derived localparam).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request; accepted in IDLE or DONE state only.
- MODE  in  3  RV32I funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- A  in  WIDTH  operand A, sampled with START.
- B  in  WIDTH  operand B, sampled with START.
- BUSY  out  1  high while slices are being processed.
- DONE  out  1  one-cycle pulse; results valid.
- EQ  out  1  A==B.
- LT  out  1  signed A<B.
- LTU  out  1  unsigned A<B.
- TAKEN  out  1  branch decision per MODE.
- ERR  out  1  MODE was 010 or 011.

Behaviour:
- Reset: state=IDLE. All outputs 0. Internal counter 0, carry 1, eq accumulator 1.
- States:
  - IDLE: START -> RUN.
  - RUN: counter reaches NCH-1 -> DONE.
  - DONE: START -> RUN (back-to-back accepted), else -> IDLE.
- On accept:
  - Latch A, B, MODE. Counter=0, carry=1, eqacc=1.
  - Clear EQ, LT, LTU, TAKEN, ERR in the same edge.
- RUN, slice k = bits [k*CHUNK +: CHUNK]:
  - {c, s} = A_k + ~B_k + carry.
  - carry <= c; eqacc <= eqacc & (s==0).
- Final slice, registered into outputs on the same edge that enters DONE:
  - LTU = ~c.
  - EQ = eqacc & (s==0).
  - LT = (A[W-1]^B[W-1]) ? A[W-1] : LTU.
- TAKEN per MODE: BEQ EQ, BNE ~EQ, BLT LT, BGE ~LT, BLTU LTU, BGEU ~LTU.
- Invalid MODE (010/011): TAKEN=0, ERR=1. EQ/LT/LTU are still computed.
- Latency: START sampled at edge e0; DONE high for exactly the cycle following edge eNCH. Default parameters give 4 cycles.
- BUSY=1 exactly in RUN. START while BUSY is ignored and the latched operands are unchanged.
- EQ/LT/LTU/TAKEN/ERR hold after DONE until the next accept or RESET.
- RESET mid-RUN: next cycle IDLE, all outputs 0, no DONE issued.
- RESET coincident with START: RESET wins.
- NCH=1 is legal: single RUN cycle.

Optional Feature:
- Macro BRCMP_SINGLE_CYCLE_EN.
- Defined: CHUNK is overridden to WIDTH, so the full subtraction happens in one RUN cycle and DONE is high the cycle after edge e1. Handshake unchanged.
- Undefined: chunked operation as above.

Decomposition:
- Shared package brcmp_pkg:
  - funct3 branch encodings (F3_BEQ ... F3_BGEU).
  - State encoding (S_IDLE, S_RUN, S_DONE).
  - A function mapping {MODE, EQ, LT, LTU} -> {TAKEN, ERR}.
- One sub-module, chunk_subtractor #(CHUNK):
  - Inputs: A_k, B_k, CIN.
  - Outputs: S, COUT, ZERO.
  - Combinational; instantiated once and reused each cycle.

Test Plan:
1. A=5, B=7, MODE=110 -> DONE exactly 4 edges after START edge; LTU=1, LT=1, EQ=0, TAKEN=1, BUSY high 4 cycles.
2. A=0xFFFFFFFF, B=1: MODE=100 -> LT=1, TAKEN=1; MODE=110 -> LTU=0, TAKEN=0.
3. A=B=0x80000000: MODE=000 -> EQ=1, TAKEN=1; MODE=001 -> TAKEN=0; MODE=101 -> TAKEN=1.
4. START pulsed mid-RUN with A=0 -> ignored, result reflects the first operands. START asserted in the DONE cycle -> new op accepted, next DONE 4 edges later.
5. RESET in the 2nd RUN cycle -> next cycle BUSY=0, all outputs 0, no DONE for 10 cycles. MODE=010 with A=B -> EQ=1, TAKEN=0, ERR=1.
6. WIDTH=8, CHUNK=2, and again with BRCMP_SINGLE_CYCLE_EN: all 65536 A,B pairs x 6 valid modes checked against a golden model (signed compare via $signed); 0 errors.
